// File: rtl/super_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : super_pkg
//  Description : Shared kudu pipeline types and helpers. Holds the
//                scoreboard entry type (one-hot pipeline + PC) and the
//                popcount / thermometer-mask helpers used by the multi-lane
//                scoreboard FIFO.
//  Revision    : 1.0 - initial multi-lane scoreboard support
// ============================================================================
package super_pkg;

    localparam int NumPlDefault = 5;

    // One scoreboard slot: which execution pipeline the instruction occupies
    // (one-hot) and its PC for trace/debug.
    typedef struct packed {
        logic [NumPlDefault-1:0] pl;
        logic [31:0]             pc;
    } sbd_entry_t;

    // Number of set bits in a lane mask of up to four lanes.
    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // A thermometer mask has all set bits contiguous from bit 0
    // (0000, 0001, 0011, 0111, 1111). Adding one to such a mask carries
    // through every set bit, so the AND is zero exactly in that case.
    function automatic logic is_thermo(input logic [3:0] v);
        return (v & (v + 4'd1)) == 4'd0;
    endfunction

endpackage : super_pkg
`default_nettype wire

// File: rtl/kudu_sbd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : kudu_sbd_fifo
//  Description : Multi-lane in-order scoreboard FIFO. Records, in program
//                order, the one-hot execution pipeline of every issued
//                instruction so that commit can retire in order.
//  Ports       : clk_i/rst_i   clock, synchronous active-high reset
//                flush_i       discard every entry (err_o is kept)
//                enq_*         EnqW issue lanes (thermometer mask, pl, pc)
//                enq_ready_o   at least EnqW free slots
//                deq_i         DeqW commit lanes (thermometer mask)
//                head_*        entries head+0 .. head+DeqW-1
//                count_o, empty_o, full_o   occupancy status
//                pl_busy_o     OR of pl over all valid entries
//                err_o         sticky protocol error
//  Revision    : 1.0 - initial release
// ============================================================================
module kudu_sbd_fifo
    import super_pkg::*;
#(
    parameter int Depth = 8,
    parameter int NumPl = NumPlDefault,
    parameter int EnqW  = 2,
    parameter int DeqW  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [EnqW-1:0]            enq_valid_i,
    input  logic [EnqW*NumPl-1:0]      enq_pl_i,
    input  logic [EnqW*32-1:0]         enq_pc_i,
    output logic                       enq_ready_o,
    input  logic [DeqW-1:0]            deq_i,
    output logic [DeqW-1:0]            head_valid_o,
    output logic [DeqW*NumPl-1:0]      head_pl_o,
    output logic [DeqW*32-1:0]         head_pc_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [NumPl-1:0]           pl_busy_o,
    output logic                       err_o
);

    localparam int PTR_W = $clog2(Depth) + 1;
    localparam int IDX_W = $clog2(Depth);
    localparam int CNT_W = $clog2(Depth + 1);

    // Storage: flop array plus per-slot valid vector.
    logic [NumPl-1:0] pl_q [Depth];
    logic [31:0]      pc_q [Depth];
    logic [Depth-1:0] valid_q;
    logic [Depth-1:0] valid_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             err_q;

    logic [PTR_W-1:0] occ;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      cnt32;
    logic [31:0]      free32;
    logic [31:0]      n32;
    logic [31:0]      m32;
    logic             enq_ok;
    logic             deq_ok;
    logic             enq_fire;
    logic             deq_fire;
    logic             pl_err;
    logic             err_set;

    // Wrap bit makes wr-rd the exact occupancy, including the full case.
    assign occ    = wr_ptr - rd_ptr;
    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign cnt32  = 32'(occ);
    assign free32 = 32'(Depth) - cnt32;
    assign n32    = 32'(popcnt4(4'(enq_valid_i)));
    assign m32    = 32'(popcnt4(4'(deq_i)));

    // Both sides are judged against the pre-edge state, so a same-cycle
    // pop never frees a slot for the enqueue in that cycle.
    assign enq_ok   = is_thermo(4'(enq_valid_i)) && (n32 <= free32);
    assign deq_ok   = is_thermo(4'(deq_i)) && (m32 <= cnt32);
    assign enq_fire = !flush_i && enq_ok && (n32 != 32'd0);
    assign deq_fire = !flush_i && deq_ok && (m32 != 32'd0);

    always_comb begin
        pl_err = 1'b0;
        for (int k = 0; k < EnqW; k++) begin
            if (enq_valid_i[k] && !$onehot(enq_pl_i[k*NumPl +: NumPl])) begin
                pl_err = 1'b1;
            end
        end
    end

    // Inputs are ignored entirely during a flush, including error detection.
    assign err_set = !flush_i && (!enq_ok || !deq_ok || pl_err);

    // Popped slots (occupied) and written slots (free) never overlap.
    always_comb begin
        valid_nxt = valid_q;
        if (deq_fire) begin
            for (int k = 0; k < DeqW; k++) begin
                if (deq_i[k]) valid_nxt[rd_idx + IDX_W'(k)] = 1'b0;
            end
        end
        if (enq_fire) begin
            for (int k = 0; k < EnqW; k++) begin
                if (enq_valid_i[k]) valid_nxt[wr_idx + IDX_W'(k)] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                pl_q[i] <= '0;
                pc_q[i] <= '0;
            end
        end else begin
            if (err_set) err_q <= 1'b1;
            if (flush_i) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                valid_q <= '0;
            end else begin
                valid_q <= valid_nxt;
                if (enq_fire) wr_ptr <= wr_ptr + PTR_W'(n32);
                if (deq_fire) rd_ptr <= rd_ptr + PTR_W'(m32);
                if (enq_fire) begin
                    for (int k = 0; k < EnqW; k++) begin
                        if (enq_valid_i[k]) begin
                            pl_q[wr_idx + IDX_W'(k)] <= enq_pl_i[k*NumPl +: NumPl];
                            pc_q[wr_idx + IDX_W'(k)] <= enq_pc_i[k*32 +: 32];
                        end
                    end
                end
            end
        end
    end

    // Status outputs depend on registered state only.
    assign count_o     = CNT_W'(occ);
    assign empty_o     = (cnt32 == 32'd0);
    assign full_o      = (cnt32 == 32'(Depth));
    assign enq_ready_o = (free32 >= 32'(EnqW));
    assign err_o       = err_q;

    always_comb begin
        head_valid_o = '0;
        head_pl_o    = '0;
        head_pc_o    = '0;
        for (int k = 0; k < DeqW; k++) begin
            head_valid_o[k]            = valid_q[rd_idx + IDX_W'(k)];
            head_pl_o[k*NumPl +: NumPl] = valid_q[rd_idx + IDX_W'(k)] ?
                                          pl_q[rd_idx + IDX_W'(k)] : '0;
            head_pc_o[k*32 +: 32]      = pc_q[rd_idx + IDX_W'(k)];
        end
    end

    always_comb begin
        pl_busy_o = '0;
        for (int i = 0; i < Depth; i++) begin
            if (valid_q[i]) pl_busy_o = pl_busy_o | pl_q[i];
        end
    end

`ifdef KUDU_SBD_SVA
    // Protocol properties; enabled only where the issue/commit stages are
    // expected to be well-behaved (err_o covers the rest at run time).
    a_enq_thermo : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        is_thermo(4'(enq_valid_i)));
    a_deq_thermo : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        is_thermo(4'(deq_i)));
    a_deq_count  : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        m32 <= cnt32);
    a_enq_free   : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        n32 <= free32);
    a_pl_onehot  : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        !pl_err);
`endif

endmodule : kudu_sbd_fifo
`default_nettype wire
